// File: rtl/dmem_port_arbiter_if.sv
// dmem_port_arbiter_if: bus bundle between the CPU load/store path, the VGA
// scanout fetcher, the shared data_ram port and the dmem_port_arbiter.
// The slave modport is the arbiter's view; master is the surrounding system.
interface dmem_port_arbiter_if #(
  parameter int I = 32,
  parameter int N = 8,
  parameter int R = 6
);
  logic             cpu_req;
  logic             cpu_we;
  logic [I-1:0]     cpu_addr;
  logic [R*N-1:0]   cpu_wdata;
  logic             cpu_gnt;
  logic             cpu_rvalid;
  logic [R*N-1:0]   cpu_rdata;

  logic             vga_req;
  logic [I-1:0]     vga_addr;
  logic             vga_gnt;
  logic             vga_rvalid;
  logic [R*N-1:0]   vga_rdata;

  logic             mem_we;
  logic [I-1:0]     mem_addr;
  logic [R*N-1:0]   mem_wdata;
  logic [R*N-1:0]   mem_rdata;

  logic [15:0]      conflicts;

  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
    input  vga_req, vga_addr,
    input  mem_rdata,
    output cpu_gnt, cpu_rvalid, cpu_rdata,
    output vga_gnt, vga_rvalid, vga_rdata,
    output mem_we, mem_addr, mem_wdata,
    output conflicts
  );

  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata,
    output vga_req, vga_addr,
    output mem_rdata,
    input  cpu_gnt, cpu_rvalid, cpu_rdata,
    input  vga_gnt, vga_rvalid, vga_rdata,
    input  mem_we, mem_addr, mem_wdata,
    input  conflicts
  );
endinterface

// File: rtl/dmem_port_arbiter.sv
// dmem_port_arbiter: shares the single data_ram port between the CPU and the
// VGA fetcher. One access per cycle, CPU has default priority, read data is
// routed back one cycle later using a registered owner tag.
// Optional feature macro: DMEM_ARB_STARVE_EN enables the VGA starvation
// override (VGA forced through after MAX_WAIT consecutive denied cycles).
// Without it the CPU has strict priority and MAX_WAIT is not used.
module dmem_port_arbiter #(
  parameter int I        = 32,
  parameter int N        = 8,
  parameter int R        = 6,
  parameter int MAX_WAIT = 4
) (
  input  logic              clk,
  input  logic              reset,
  dmem_port_arbiter_if.slave bus
);
  localparam int W = R * N;

  typedef enum logic [1:0] {OWN_NONE, OWN_CPU, OWN_VGA} owner_t;

  if (MAX_WAIT < 1 || MAX_WAIT > 15) begin : g_bad_max_wait
    $error("dmem_port_arbiter: MAX_WAIT must be in 1..15");
  end

  logic          cpu_gnt;
  logic          vga_gnt;
  logic          vga_force;
  logic          mem_we;
  logic [I-1:0]  mem_addr;
  logic [W-1:0]  mem_wdata;

  owner_t        owner;
  logic [I-1:0]  addr_q;
  logic [W-1:0]  cpu_rdata_q;
  logic [W-1:0]  vga_rdata_q;
  logic [15:0]   conflicts;

`ifdef DMEM_ARB_STARVE_EN
  logic [3:0] wait_cnt;

  assign vga_force = bus.vga_req && (wait_cnt == 4'(MAX_WAIT));

  // Count consecutive cycles VGA asked but was refused, saturating at MAX_WAIT.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wait_cnt <= 4'd0;
    end else if (!bus.vga_req || vga_gnt) begin
      wait_cnt <= 4'd0;
    end else if (wait_cnt != 4'(MAX_WAIT)) begin
      wait_cnt <= wait_cnt + 4'd1;
    end
  end
`else
  assign vga_force = 1'b0;
`endif

  // CPU wins unless VGA has been starved; VGA takes any cycle the CPU leaves.
  assign cpu_gnt = bus.cpu_req && !vga_force;
  assign vga_gnt = bus.vga_req && !cpu_gnt;

  // Steer the memory port to the granted requester; idle cycles keep the address.
  always_comb begin
    mem_we    = 1'b0;
    mem_addr  = addr_q;
    mem_wdata = '0;
    if (cpu_gnt) begin
      mem_we    = bus.cpu_we && reset;
      mem_addr  = bus.cpu_addr;
      mem_wdata = bus.cpu_wdata;
    end else if (vga_gnt) begin
      mem_addr  = bus.vga_addr;
    end
  end

  // Tag each granted read with its owner, remember the address and held read
  // words, and count contention cycles.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      owner       <= OWN_NONE;
      addr_q      <= '0;
      cpu_rdata_q <= '0;
      vga_rdata_q <= '0;
      conflicts   <= 16'd0;
    end else begin
      if (cpu_gnt && !bus.cpu_we) begin
        owner <= OWN_CPU;
      end else if (vga_gnt) begin
        owner <= OWN_VGA;
      end else begin
        owner <= OWN_NONE;
      end
      addr_q <= mem_addr;
      if (owner == OWN_CPU) begin
        cpu_rdata_q <= bus.mem_rdata;
      end
      if (owner == OWN_VGA) begin
        vga_rdata_q <= bus.mem_rdata;
      end
      if (bus.cpu_req && bus.vga_req && conflicts != 16'hFFFF) begin
        conflicts <= conflicts + 16'd1;
      end
    end
  end

  assign bus.cpu_gnt    = cpu_gnt;
  assign bus.vga_gnt    = vga_gnt;
  assign bus.mem_we     = mem_we;
  assign bus.mem_addr   = mem_addr;
  assign bus.mem_wdata  = mem_wdata;
  assign bus.cpu_rvalid = (owner == OWN_CPU);
  assign bus.vga_rvalid = (owner == OWN_VGA);
  assign bus.cpu_rdata  = (owner == OWN_CPU) ? bus.mem_rdata : cpu_rdata_q;
  assign bus.vga_rdata  = (owner == OWN_VGA) ? bus.mem_rdata : vga_rdata_q;
  assign bus.conflicts  = conflicts;

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// tb_dmem_port_arbiter: directed and randomized cycles against a behavioural
// model of the arbiter (winner choice, starvation count, pending read queue,
// memory image). A small RAM model provides mem_rdata one cycle after address.
module tb_dmem_port_arbiter;
  localparam int I        = 32;
  localparam int N        = 8;
  localparam int R        = 6;
  localparam int W        = R * N;
  localparam int MAX_WAIT = 4;

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  dmem_port_arbiter_if #(.I(I), .N(N), .R(R)) bus ();

  dmem_port_arbiter #(.I(I), .N(N), .R(R), .MAX_WAIT(MAX_WAIT)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  logic [W-1:0] ram [16];

  // Synchronous-read RAM standing in for data_ram.
  always @(posedge clk) begin
    if (bus.mem_we) ram[bus.mem_addr[3:0]] <= bus.mem_wdata;
    bus.mem_rdata <= ram[bus.mem_addr[3:0]];
  end

  int tests = 0;
  int fails = 0;

  logic [W-1:0] mdl_mem [16];
  int           denied;
  int           conf_cnt;
  logic         pend_cpu;
  logic         pend_vga;
  logic [W-1:0] pend_data;
  logic [W-1:0] last_cpu_rd;
  logic [W-1:0] last_vga_rd;
  logic [I-1:0] last_addr;

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic modelReset();
    denied      = 0;
    conf_cnt    = 0;
    pend_cpu    = 1'b0;
    pend_vga    = 1'b0;
    pend_data   = '0;
    last_cpu_rd = '0;
    last_vga_rd = '0;
    last_addr   = '0;
  endtask

  task automatic checkReturned();
    logic [W-1:0] exp_cpu;
    logic [W-1:0] exp_vga;
    exp_cpu = pend_cpu ? pend_data : last_cpu_rd;
    exp_vga = pend_vga ? pend_data : last_vga_rd;
    checkOutput("cpu_rvalid", 64'(bus.cpu_rvalid), 64'(pend_cpu));
    checkOutput("vga_rvalid", 64'(bus.vga_rvalid), 64'(pend_vga));
    checkOutput("cpu_rdata",  64'(bus.cpu_rdata),  64'(exp_cpu));
    checkOutput("vga_rdata",  64'(bus.vga_rdata),  64'(exp_vga));
    checkOutput("conflicts",  64'(bus.conflicts),  64'(conf_cnt));
    last_cpu_rd = exp_cpu;
    last_vga_rd = exp_vga;
  endtask

  task automatic applyStimulus(input logic cr, input logic cwe, input logic [I-1:0] caddr,
                               input logic [W-1:0] cwd, input logic vr, input logic [I-1:0] vaddr);
    bit forced;
    bit win_cpu;
    bit win_vga;
    logic [I-1:0] exp_addr;
    @(negedge clk);
    bus.cpu_req   = cr;
    bus.cpu_we    = cwe;
    bus.cpu_addr  = caddr;
    bus.cpu_wdata = cwd;
    bus.vga_req   = vr;
    bus.vga_addr  = vaddr;
    #1;
    checkReturned();
`ifdef DMEM_ARB_STARVE_EN
    forced = vr && (denied >= MAX_WAIT);
`else
    forced = 1'b0;
`endif
    if (cr && vr) begin
      win_cpu = !forced;
      win_vga = forced;
    end else begin
      win_cpu = cr;
      win_vga = vr;
    end
    exp_addr = win_cpu ? caddr : (win_vga ? vaddr : last_addr);
    checkOutput("cpu_gnt",   64'(bus.cpu_gnt),   64'(win_cpu));
    checkOutput("vga_gnt",   64'(bus.vga_gnt),   64'(win_vga));
    checkOutput("mem_addr",  64'(bus.mem_addr),  64'(exp_addr));
    checkOutput("mem_we",    64'(bus.mem_we),    64'(win_cpu && cwe));
    checkOutput("mem_wdata", 64'(bus.mem_wdata), win_cpu ? 64'(cwd) : 64'd0);
    if (cr && vr && conf_cnt < 65535) conf_cnt++;
    denied    = (vr && !win_vga) ? denied + 1 : 0;
    pend_cpu  = win_cpu && !cwe;
    pend_vga  = win_vga;
    pend_data = mdl_mem[exp_addr[3:0]];
    if (win_cpu && cwe) mdl_mem[caddr[3:0]] = cwd;
    last_addr = exp_addr;
  endtask

  task automatic idleCycle();
    applyStimulus(1'b0, 1'b0, '0, '0, 1'b0, '0);
  endtask

  // Pulse reset in the cycle after the previous grant, with requests active.
  task automatic midReset();
    @(negedge clk);
    reset       = 1'b0;
    bus.cpu_req = 1'b1;
    bus.cpu_we  = 1'b1;
    bus.vga_req = 1'b1;
    #1;
    checkOutput("rst_cpu_rvalid", 64'(bus.cpu_rvalid), 64'd0);
    checkOutput("rst_vga_rvalid", 64'(bus.vga_rvalid), 64'd0);
    checkOutput("rst_conflicts",  64'(bus.conflicts),  64'd0);
    checkOutput("rst_mem_we",     64'(bus.mem_we),     64'd0);
    modelReset();
    @(negedge clk);
    bus.cpu_req = 1'b0;
    bus.cpu_we  = 1'b0;
    bus.vga_req = 1'b0;
    reset       = 1'b1;
    #1;
    checkOutput("rst_mem_addr",  64'(bus.mem_addr),  64'd0);
    checkOutput("rst_cpu_rdata", 64'(bus.cpu_rdata), 64'd0);
    checkOutput("rst_vga_rdata", 64'(bus.vga_rdata), 64'd0);
    checkOutput("rst_vga_rv2",   64'(bus.vga_rvalid), 64'd0);
  endtask

  initial begin
    for (int i = 0; i < 16; i++) begin
      ram[i]     = '0;
      mdl_mem[i] = '0;
    end
    reset         = 1'b0;
    bus.cpu_req   = 1'b0;
    bus.cpu_we    = 1'b0;
    bus.cpu_addr  = '0;
    bus.cpu_wdata = '0;
    bus.vga_req   = 1'b0;
    bus.vga_addr  = '0;
    modelReset();
    repeat (3) @(negedge clk);
    #1;
    checkOutput("init_cpu_rvalid", 64'(bus.cpu_rvalid), 64'd0);
    checkOutput("init_vga_rvalid", 64'(bus.vga_rvalid), 64'd0);
    checkOutput("init_conflicts",  64'(bus.conflicts),  64'd0);
    checkOutput("init_mem_addr",   64'(bus.mem_addr),   64'd0);
    checkOutput("init_mem_we",     64'(bus.mem_we),     64'd0);
    reset = 1'b1;

    // CPU write then reads, VGA idle.
    applyStimulus(1'b1, 1'b1, 32'd10, 48'h0102_0304_0506, 1'b0, '0);
    applyStimulus(1'b1, 1'b0, 32'd10, '0, 1'b0, '0);
    applyStimulus(1'b1, 1'b0, 32'd5,  '0, 1'b0, '0);
    idleCycle();

    // Seed words 1..3 then alternate CPU/VGA/CPU reads.
    applyStimulus(1'b1, 1'b1, 32'd1, 48'hAAAA_0000_0001, 1'b0, '0);
    applyStimulus(1'b1, 1'b1, 32'd2, 48'hBBBB_0000_0002, 1'b0, '0);
    applyStimulus(1'b1, 1'b1, 32'd3, 48'hCCCC_0000_0003, 1'b0, '0);
    applyStimulus(1'b1, 1'b0, 32'd1, '0, 1'b0, '0);
    applyStimulus(1'b0, 1'b0, '0,    '0, 1'b1, 32'd2);
    applyStimulus(1'b1, 1'b0, 32'd3, '0, 1'b0, '0);
    idleCycle();

    // Sustained contention, then CPU backs off.
    for (int c = 0; c < 12; c++)
      applyStimulus(1'b1, 1'b0, 32'(c), '0, 1'b1, 32'(c + 7));
    applyStimulus(1'b0, 1'b0, '0, '0, 1'b1, 32'd9);
    idleCycle();

    // VGA read immediately followed by reset.
    applyStimulus(1'b0, 1'b0, '0, '0, 1'b1, 32'd2);
    midReset();
    applyStimulus(1'b1, 1'b0, 32'd3, '0, 1'b0, '0);
    idleCycle();

    // Randomized traffic with occasional resets.
    for (int k = 0; k < 400; k++) begin
      if ($urandom_range(0, 99) == 0) begin
        midReset();
      end else begin
        applyStimulus($urandom_range(0, 3) != 0, $urandom_range(0, 2) == 0, $urandom(),
                      W'({$urandom(), $urandom()}), $urandom_range(0, 2) != 0, $urandom());
      end
    end
    idleCycle();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
